// File: rtl/csa_resolver_if.sv
// Handshake bundle between the carry-save compressor, the resolver and the
// downstream consumer. The resolver sits on the slave side.
interface csa_resolver_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_cout
  );

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_cout
  );
endinterface

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate stage: folds a carry-save pair into one binary
// word, resolving SLICE bits per cycle so the ripple path stays one slice long.
module csa_resolver #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_resolver_if.slave   bus,
  output logic            busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [IW-1:0]    idx;
  logic             c;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             out_valid_q;
  logic [SLICE:0]   slice_add;

  // One slice of the carry-propagate add, carry-in from the previous slice.
  assign slice_add = {1'b0, sum_q[idx*SLICE +: SLICE]}
                   + {1'b0, carry_q[idx*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, c};

  // in_ready must drop with rst_n itself, not wait for the state to settle.
  assign bus.in_ready   = rst_n && (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_cout   = cout_q;
  assign busy           = (state != IDLE);

  // Control FSM plus datapath registers; result slices are written in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      idx         <= '0;
      c           <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sum_q   <= bus.in_sum;
            carry_q <= bus.in_carry;
            idx     <= '0;
            c       <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          result_q[idx*SLICE +: SLICE] <= slice_add[SLICE-1:0];
          c   <= slice_add[SLICE];
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q      <= slice_add[SLICE];
            out_valid_q <= 1'b1;
            idx         <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver: reset, latency, ripple/overflow,
// backpressure, mid-run reset and a randomised compressor-fed sequence.
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  csa_resolver_if #(.WIDTH(32)) bus ();

  csa_resolver #(.WIDTH(32), .SLICE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until out_valid is high.
  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // One full transaction; out_ready held low for 'hold' cycles in DONE.
  task automatic do_txn(input logic [31:0] s, input logic [31:0] cr, input int hold,
                        output logic [31:0] res, output logic co);
    int t;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sum    = s;
    bus.in_carry  = cr;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sum   = $urandom;
    bus.in_carry = $urandom;
    wait_out("txn");
    res = bus.out_result;
    co  = bus.out_cout;
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("txn_ov_drop", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic        co;
    logic [31:0] a, b, c3, s, cy;
    logic [63:0] full;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result",    {32'd0, bus.out_result}, 64'd0);
    chk("rst_cout",      {63'd0, bus.out_cout},  64'd0);
    chk("rst_busy",      {63'd0, busy},          64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Cross-slice carry with exact latency and one-cycle out_valid
    bus.in_valid  = 1'b1;
    bus.in_sum    = 32'h0000_00FF;
    bus.in_carry  = 32'h0000_0001;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sum   = 32'hDEAD_BEEF;
    chk("lat_busy", {63'd0, busy}, 64'd1);
    chk("lat_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat_ov_early", {63'd0, bus.out_valid}, 64'd0);
    end
    @(negedge clk);
    chk("lat_ov_e4",   {63'd0, bus.out_valid}, 64'd1);
    chk("xslice_res",  {32'd0, bus.out_result}, 64'h0000_0100);
    chk("xslice_cout", {63'd0, bus.out_cout}, 64'd0);
    @(negedge clk);
    chk("lat_ov_1cyc", {63'd0, bus.out_valid}, 64'd0);
    chk("lat_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b0;

    // Full ripple and overflow
    do_txn(32'hFFFF_FFFF, 32'h0000_0001, 0, res, co);
    chk("ripple_res", {32'd0, res}, 64'd0);
    chk("ripple_cout", {63'd0, co}, 64'd1);
    do_txn(32'h8000_0000, 32'h8000_0000, 1, res, co);
    chk("msb_res", {32'd0, res}, 64'd0);
    chk("msb_cout", {63'd0, co}, 64'd1);
    do_txn(32'h0000_0001, 32'h0000_0001, 0, res, co);
    chk("lsb_carry_res", {32'd0, res}, 64'h2);

    // Backpressure with a competing pair waiting upstream
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h1234_5678;
    bus.in_carry = 32'h1111_1111;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("bp");
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'hF000_0000;
    bus.in_carry = 32'h2000_0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_ov",       {63'd0, bus.out_valid}, 64'd1);
      chk("bp_res",      {32'd0, bus.out_result}, 64'h2345_6789);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_hs_ov", {63'd0, bus.out_valid}, 64'd0);
    chk("bp_hs_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_accept_busy", {63'd0, busy}, 64'd1);
    wait_out("bp2");
    chk("bp_new_res",  {32'd0, bus.out_result}, 64'h1000_0000);
    chk("bp_new_cout", {63'd0, bus.out_cout}, 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while in DONE clears the held result
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h0F0F_0F0F;
    bus.in_carry = 32'h0101_0101;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("done_rst");
    chk("pre_rst_res", {32'd0, bus.out_result}, 64'h1010_1010);
    #1 rst_n = 1'b0;
    #1;
    chk("done_rst_ov",  {63'd0, bus.out_valid}, 64'd0);
    chk("done_rst_res", {32'd0, bus.out_result}, 64'd0);
    chk("done_rst_ir",  {63'd0, bus.in_ready}, 64'd0);
    chk("done_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset two cycles into RUN; stale carry must not leak
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'hFFFF_FFFF;
    bus.in_carry = 32'h0000_0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("run_rst_busy", {63'd0, busy}, 64'd0);
    chk("run_rst_ir",   {63'd0, bus.in_ready}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("run_rst_no_ov", {63'd0, bus.out_valid}, 64'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("run_rel_no_ov", {63'd0, bus.out_valid}, 64'd0);
    end
    do_txn(32'h0000_0001, 32'h0000_0001, 0, res, co);
    chk("post_rst_res",  {32'd0, res}, 64'h2);
    chk("post_rst_cout", {63'd0, co}, 64'd0);

    // Compressor-fed random sequence with random gaps and backpressure
    for (int n = 0; n < 60; n++) begin
      a  = $urandom;
      b  = $urandom;
      c3 = $urandom;
      s  = a ^ b ^ c3;
      cy = ((a & b) | (a & c3) | (b & c3)) << 1;
      full = {32'd0, a} + {32'd0, b} + {32'd0, c3};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(s, cy, $urandom_range(0, 3), res, co);
      chk("rand_res", {32'd0, res}, {32'd0, full[31:0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
